// File: rtl/auth_timeout_bank.sv
// auth_timeout_bank: N_CH independent authentication timeout channels with sticky expiry.
// Optional shared tick prescaler is built when TIMEOUT_PRESCALER_EN is defined.
module auth_timeout_bank #(
   parameter int N_CH       = 4,
   parameter int CNT_W      = 32,
   parameter int PRESCALE_W = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_CH-1:0]         start,
   input  logic [N_CH-1:0]         stop,
   input  logic [N_CH-1:0]         err_clr,
   input  logic [N_CH*CNT_W-1:0]   timeout_val,
   input  logic [PRESCALE_W-1:0]   prescale_div,
   output logic [N_CH-1:0]         busy,
   output logic [N_CH-1:0]         expired,
   output logic [N_CH-1:0]         expired_pulse,
   output logic                    error_busy
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_EXPIRED = 2'd2
   } ch_state_t;

   logic tick;

`ifdef TIMEOUT_PRESCALER_EN
   logic [PRESCALE_W-1:0] psc_q;

   assign tick = (psc_q == prescale_div);

   // A divider lowered below the current count wraps through the counter maximum.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         psc_q <= '0;
      end else if (tick) begin
         psc_q <= '0;
      end else begin
         psc_q <= psc_q + PRESCALE_W'(1);
      end
   end
`else
   logic unused_prescale;

   assign tick            = 1'b1;
   assign unused_prescale = ^prescale_div;
`endif

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      ch_state_t        state_q;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] limit_q;
      logic             pulse_q;
      logic [CNT_W-1:0] new_limit;
      logic [CNT_W-1:0] cnt_inc;
      logic             new_zero;
      ch_state_t        restart_state;

      assign new_limit     = timeout_val[i*CNT_W +: CNT_W];
      assign cnt_inc       = cnt_q + CNT_W'(1);
      assign new_zero      = (new_limit == '0);
      assign restart_state = new_zero ? ST_EXPIRED : ST_RUN;

      // NOTE: state is updated with non-blocking assignments so every flop in this
      // block samples pre-edge values, independent of statement order.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            limit_q <= '0;
            pulse_q <= 1'b0;
         end else begin
            pulse_q <= 1'b0;
            unique case (state_q)
               ST_IDLE: begin
                  if (stop[i]) begin
                     cnt_q <= '0;
                  end else if (start[i]) begin
                     limit_q <= new_limit;
                     cnt_q   <= '0;
                     state_q <= restart_state;
                     pulse_q <= new_zero;
                  end
               end
               ST_RUN: begin
                  if (stop[i]) begin
                     state_q <= ST_IDLE;
                     cnt_q   <= '0;
                  end else if (start[i]) begin
                     limit_q <= new_limit;
                     cnt_q   <= '0;
                     state_q <= restart_state;
                     pulse_q <= new_zero;
                  end else if (tick) begin
                     // Equality compare: the count stops at the limit and never wraps.
                     cnt_q <= cnt_inc;
                     if (cnt_inc == limit_q) begin
                        state_q <= ST_EXPIRED;
                        pulse_q <= 1'b1;
                     end
                  end
               end
               ST_EXPIRED: begin
                  if (stop[i] || err_clr[i]) begin
                     state_q <= ST_IDLE;
                     cnt_q   <= '0;
                  end else if (start[i]) begin
                     limit_q <= new_limit;
                     cnt_q   <= '0;
                     state_q <= restart_state;
                     pulse_q <= new_zero;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end
            endcase
         end
      end

      assign busy[i]          = (state_q == ST_RUN);
      assign expired[i]       = (state_q == ST_EXPIRED);
      assign expired_pulse[i] = pulse_q;
   end

   // Aggregate lags the per-channel expiry by one edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         error_busy <= 1'b0;
      end else begin
         error_busy <= |expired;
      end
   end

endmodule

// File: doc/auth_timeout_bank.md
# auth_timeout_bank

Multi-channel timeout timer for the USB Type-C authentication driver. It generalises the single shared timeout counter into N_CH independent channels, one per outstanding authentication transaction (e.g. GET_DIGESTS, GET_CERTIFICATE, CHALLENGE). Each channel has its own start/stop, a latched limit, and sticky expiry with explicit clear. An aggregated `error_busy` feeds the protocol state machine in place of the former single error flag.

## Interface
- `N_CH`, default 4: number of independent timeout channels (1..16).
- `CNT_W`, default 32: counter and limit width in bits.
- `PRESCALE_W`, default 8: prescaler divider width. Used only with `TIMEOUT_PRESCALER_EN`.

- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  N_CH: per-channel start/restart request, level-sampled each edge.
- `stop`  in  N_CH: per-channel stop; the response message arrived (auth_msg_ready per channel).
- `err_clr`  in  N_CH: per-channel clear of sticky expiry.
- `timeout_val`  in  N_CH*CNT_W: per-channel limit in ticks. Channel i uses bits [i*CNT_W +: CNT_W].
- `prescale_div`  in  PRESCALE_W: tick period minus one.
- `busy`  out  N_CH: channel i in RUN.
- `expired`  out  N_CH: channel i in EXPIRED (sticky).
- `expired_pulse`  out  N_CH: one-cycle pulse on entry to EXPIRED.
- `error_busy`  out  1: OR of `expired`, registered.

## Operation
- Each channel has its own FSM with encoding IDLE=0, RUN=1, EXPIRED=2, plus `cnt[CNT_W]` and `limit[CNT_W]` registers.
- A tick is a shared enable. Counting advances only on edges where tick=1.
- **IDLE**
  - `start` latches `limit<=timeout_val[i]` and sets `cnt<=0`.
  - If the latched value is 0, go directly to EXPIRED. Otherwise go to RUN.
- **RUN**
  - `stop`: go to IDLE, `cnt<=0`.
  - Else `start`: restart. Relatch `limit`, `cnt<=0`, remain in RUN. The zero-limit rule applies as in IDLE.
  - Else on tick: `cnt<=cnt+1`. If `cnt+1==limit`, go to EXPIRED.
- **EXPIRED**
  - `stop` or `err_clr`: go to IDLE, `cnt<=0`.
  - Else `start`: restart as in RUN. Expiry clears on the same edge.
  - Otherwise hold. `cnt` is frozen at `limit`.
- Priority per channel: `stop` > `err_clr` > `start` > tick. `err_clr` has no effect in IDLE or RUN.
- `timeout_val` changes while in RUN do not affect the channel until the next start.
- Counter arithmetic is CNT_W-bit unsigned. Because the compare is equality, wrap cannot occur: maximum limit 2^CNT_W−1 expires exactly at that count.
- Channels are fully independent. Simultaneous events on different channels are all honoured on the same edge.

## Timing
- Reset (async assert, synchronous release on the next `clk` edge):
  - All channels go to IDLE with `cnt=0`, `limit=0`.
  - `busy`, `expired`, `expired_pulse`, `error_busy` = 0.
  - Prescaler count = 0.
- All outputs are registered. `busy` and `expired` are decoded from state flops.
- With tick=1 every cycle, `start` is sampled at edge k and limit L ≥ 1:
  - `busy` goes high after edge k.
  - `expired` and `expired_pulse` go high after edge k+L.
  - `error_busy` goes high after edge k+L+1.
- Zero limit: `expired` goes high after edge k.
- `stop` sampled at edge j with j < k+L guarantees no expiry.
- A `stop` coincident with the expiring edge wins: the channel goes to IDLE and no pulse is issued.
- Reset asserted mid-RUN aborts immediately. After release, no pulse is issued.

## Configuration
- Macro `TIMEOUT_PRESCALER_EN`.
- **Defined:**
  - A shared free-running PRESCALE_W-bit counter counts 0..`prescale_div`.
  - tick=1 on the cycle the counter equals `prescale_div`, then the counter wraps to 0.
  - `prescale_div=0` gives tick every cycle.
  - A change to `prescale_div` below the current count causes the count to wrap through its maximum. This behaviour is accepted.
- **Undefined:**
  - tick is hardwired to 1.
  - The `prescale_div` port remains but is ignored.
  - No prescaler flops are synthesised.

## Test plan
- Channel 0, `timeout_val`=5, `start` pulse at edge 10, no stop:
  - `busy[0]`=1 from edge 10.
  - `expired[0]` and `expired_pulse[0]` go high after edge 15; pulse lasts one cycle.
  - `error_busy`=1 after edge 16.
- Channel 1, limit 5, `stop[1]` at edge 14:
  - Channel returns to IDLE and never expires.
  - Repeat with `stop[1]` at edge 15 (coincident with expiry): no pulse, IDLE.
- Channel 2 expired, apply `err_clr[2]` and `start[2]` on the same edge:
  - Channel goes to IDLE.
  - A separate `start[2]` alone from EXPIRED restarts, with `expired[2]` low the next cycle.
- Zero limit: `start[3]` with `timeout_val`=0 → `expired[3]` high after that same edge.
- All 4 channels started together with limits 3/6/9/12:
  - Pulses occur after edges +3/+6/+9/+12.
  - Assert `reset` asynchronously at +7 → all outputs 0 immediately, with no later pulses.
- With `TIMEOUT_PRESCALER_EN`, `prescale_div`=3, limit 4: expiry occurs within 16 cycles (±3 for phase) of start. Without the macro the same stimulus expires after 4 cycles.
